// File: rtl/us_power_ctrl.sv
// Ultrasonic drive command stage: edge-triggered power commands, slew-ramped DAC level
// with valid/ready handshake, and IDLE/BURST/RX transducer sequencing.
module us_power_ctrl #(
    parameter int DAC_WIDTH    = 8,
    parameter int AMOUNT_WIDTH = 8,
    parameter int RAMP_DIV     = 16,
    parameter int PULSE_PERIOD = 10,
    parameter int BURST_PULSES = 8,
    parameter int RX_WINDOW    = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    on,
    input  logic                    off,
    input  logic                    increase,
    input  logic                    decrease,
    input  logic                    valid,
    input  logic                    send,
    input  logic                    receive,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    output logic                    dac_valid,
    input  logic                    dac_ready,
    output logic [DAC_WIDTH-1:0]    dac_data,
    output logic                    enabled,
    output logic                    tx_pulse,
    output logic                    rx_window,
    output logic                    busy
);
    localparam int NCMD   = 6;
    localparam int C_ON   = 0;
    localparam int C_OFF  = 1;
    localparam int C_INC  = 2;
    localparam int C_DEC  = 3;
    localparam int C_SEND = 4;
    localparam int C_RECV = 5;

    localparam int RAMP_W = $clog2(RAMP_DIV);
    localparam int PER_W  = $clog2(PULSE_PERIOD);
    localparam int PUL_W  = (BURST_PULSES > 1) ? $clog2(BURST_PULSES) : 1;
    localparam int RX_W   = (RX_WINDOW > 1) ? $clog2(RX_WINDOW) : 1;
    localparam logic [DAC_WIDTH:0] MAX_EXT = {1'b0, {DAC_WIDTH{1'b1}}};

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_RX} state_t;

    logic [NCMD-1:0]      cmd_vec;
    logic [NCMD-1:0]      cmd_prev_reg;
    logic [NCMD-1:0]      cmd_event;
    logic                 on_only;
    logic                 off_only;

    logic                 enabled_reg, enabled_next;
    logic [DAC_WIDTH-1:0] target_reg, target_next;
    logic [DAC_WIDTH-1:0] level_reg, level_next;
    logic                 dac_valid_reg, dac_valid_next;
    logic [RAMP_W-1:0]    ramp_cnt_reg, ramp_cnt_next;
    logic                 ramp_term;
    logic [DAC_WIDTH-1:0] eff_target;
    logic [DAC_WIDTH:0]   amount_ext;
    logic [DAC_WIDTH:0]   sum_ext;

    state_t               state_reg, state_next;
    logic [PER_W-1:0]     period_cnt_reg, period_cnt_next;
    logic [PUL_W-1:0]     pulse_cnt_reg, pulse_cnt_next;
    logic [RX_W-1:0]      rx_cnt_reg, rx_cnt_next;

    assign cmd_vec = {receive, send, decrease, increase, off, on};

    for (genvar gi = 0; gi < NCMD; gi++) begin : g_edge
        assign cmd_event[gi] = valid && cmd_vec[gi] && !cmd_prev_reg[gi];
    end

    // Opposing command pairs cancel each other entirely.
    assign on_only  = cmd_event[C_ON] && !cmd_event[C_OFF];
    assign off_only = cmd_event[C_OFF] && !cmd_event[C_ON];

    assign amount_ext = {{(DAC_WIDTH + 1 - AMOUNT_WIDTH){1'b0}}, amount};
    assign sum_ext    = {1'b0, target_reg} + amount_ext;
    assign eff_target = enabled_reg ? target_reg : '0;
    assign ramp_term  = (ramp_cnt_reg == RAMP_W'(RAMP_DIV - 1));

    always_comb begin
        enabled_next = enabled_reg;
        target_next  = target_reg;
        if (on_only) begin
            enabled_next = 1'b1;
        end else if (off_only) begin
            enabled_next = 1'b0;
        end
        if (cmd_event[C_INC] && !cmd_event[C_DEC]) begin
            target_next = (sum_ext > MAX_EXT) ? MAX_EXT[DAC_WIDTH-1:0] : sum_ext[DAC_WIDTH-1:0];
        end else if (cmd_event[C_DEC] && !cmd_event[C_INC]) begin
            target_next = (amount_ext > {1'b0, target_reg}) ? '0
                        : target_reg - amount_ext[DAC_WIDTH-1:0];
        end
    end

    // A step is only taken on a terminal count with no transfer outstanding.
    always_comb begin
        ramp_cnt_next  = ramp_term ? '0 : ramp_cnt_reg + 1'b1;
        level_next     = level_reg;
        dac_valid_next = dac_valid_reg;
        if (dac_valid_reg) begin
            if (dac_ready) begin
                dac_valid_next = 1'b0;
            end
        end else if (ramp_term && (level_reg != eff_target)) begin
            level_next     = (level_reg < eff_target) ? level_reg + 1'b1 : level_reg - 1'b1;
            dac_valid_next = 1'b1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        period_cnt_next = period_cnt_reg;
        pulse_cnt_next  = pulse_cnt_reg;
        rx_cnt_next     = rx_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!off_only) begin
                    if (cmd_event[C_SEND] && enabled_reg && (level_reg != '0)) begin
                        state_next      = ST_BURST;
                        period_cnt_next = '0;
                        pulse_cnt_next  = '0;
                    end else if (cmd_event[C_RECV]) begin
                        state_next  = ST_RX;
                        rx_cnt_next = '0;
                    end
                end
            end
            ST_BURST: begin
                if (off_only) begin
                    state_next = ST_IDLE;
                end else if (period_cnt_reg == PER_W'(PULSE_PERIOD - 1)) begin
                    period_cnt_next = '0;
                    if (pulse_cnt_reg == PUL_W'(BURST_PULSES - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        pulse_cnt_next = pulse_cnt_reg + 1'b1;
                    end
                end else begin
                    period_cnt_next = period_cnt_reg + 1'b1;
                end
            end
            ST_RX: begin
                if (off_only || (rx_cnt_reg == RX_W'(RX_WINDOW - 1))) begin
                    state_next = ST_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_prev_reg   <= '0;
            enabled_reg    <= 1'b0;
            target_reg     <= '0;
            level_reg      <= '0;
            dac_valid_reg  <= 1'b0;
            ramp_cnt_reg   <= '0;
            state_reg      <= ST_IDLE;
            period_cnt_reg <= '0;
            pulse_cnt_reg  <= '0;
            rx_cnt_reg     <= '0;
        end else begin
            cmd_prev_reg   <= cmd_vec;
            enabled_reg    <= enabled_next;
            target_reg     <= target_next;
            level_reg      <= level_next;
            dac_valid_reg  <= dac_valid_next;
            ramp_cnt_reg   <= ramp_cnt_next;
            state_reg      <= state_next;
            period_cnt_reg <= period_cnt_next;
            pulse_cnt_reg  <= pulse_cnt_next;
            rx_cnt_reg     <= rx_cnt_next;
        end
    end

    assign dac_valid = dac_valid_reg;
    assign dac_data  = level_reg;
    assign enabled   = enabled_reg;
    assign tx_pulse  = (state_reg == ST_BURST) && (period_cnt_reg < PER_W'(PULSE_PERIOD / 2));
    assign rx_window = (state_reg == ST_RX);
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_us_power_ctrl.sv
// Directed bench for us_power_ctrl: DAC transfers are checked by a scoreboard monitor,
// burst/receive sequencing and command gating are checked inline.
module tb_us_power_ctrl;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int RD  = 4;
    localparam int PP  = 10;
    localparam int BP  = 8;
    localparam int RXW = 1000;

    localparam logic [5:0] M_ON   = 6'b100000;
    localparam logic [5:0] M_OFF  = 6'b010000;
    localparam logic [5:0] M_INC  = 6'b001000;
    localparam logic [5:0] M_DEC  = 6'b000100;
    localparam logic [5:0] M_SEND = 6'b000010;
    localparam logic [5:0] M_RECV = 6'b000001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          on = 1'b0, off = 1'b0, increase = 1'b0, decrease = 1'b0;
    logic          send = 1'b0, receive = 1'b0, valid = 1'b1;
    logic [AW-1:0] amount = '0;
    logic          dac_ready = 1'b1;
    logic          dac_valid;
    logic [DW-1:0] dac_data;
    logic          enabled, tx_pulse, rx_window, busy;

    us_power_ctrl #(
        .DAC_WIDTH(DW), .AMOUNT_WIDTH(AW), .RAMP_DIV(RD),
        .PULSE_PERIOD(PP), .BURST_PULSES(BP), .RX_WINDOW(RXW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .on(on), .off(off), .increase(increase),
        .decrease(decrease), .valid(valid), .send(send), .receive(receive),
        .amount(amount), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .dac_data(dac_data), .enabled(enabled), .tx_pulse(tx_pulse),
        .rx_window(rx_window), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [DW-1:0] data;
        bit            chained;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected DAC levels from 'from' to 'to'; chained entries follow their predecessor by RD cycles.
    task automatic push_ramp(input int from, input int to, input bit first_chained);
        int v;
        exp_t e;
        v = from;
        forever begin
            e.data    = DW'(v);
            e.chained = (v == from) ? first_chained : 1'b1;
            exp_q.push_back(e);
            if (v == to) break;
            v += (to > from) ? 1 : -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_cmd(input logic [5:0] mask, input logic [AW-1:0] amt, input logic v);
        {on, off, increase, decrease, send, receive} = mask;
        amount = amt;
        valid  = v;
        step();
        {on, off, increase, decrease, send, receive} = 6'b0;
        valid = 1'b1;
    endtask

    task automatic wait_level(input int lvl, input int budget, input string name);
        int n;
        n = 0;
        while (!(dac_data == DW'(lvl) && !dac_valid && exp_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        check(name, dac_data, lvl);
        check({name, "_q"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dac_valid"}, dac_valid, 0);
        check({tag, "_dac_data"}, dac_data, 0);
        check({tag, "_enabled"}, enabled, 0);
        check({tag, "_tx_pulse"}, tx_pulse, 0);
        check({tag, "_rx_window"}, rx_window, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Scoreboard monitor: each accepted DAC transfer must match the next expected level.
    initial begin
        exp_t e;
        int   last_cyc;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_n && dac_valid && dac_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dac_unexpected: transfer of %0d with nothing expected", dac_data);
                end else begin
                    e = exp_q.pop_front();
                    check("dac_data", dac_data, e.data);
                    if (e.chained) check("dac_gap", cyc - last_cyc, RD);
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        int n;
        int nbusy;

        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        pulse_cmd(M_ON, 0, 1);
        check("enabled_on", enabled, 1);

        pulse_cmd(M_SEND, 0, 1);
        nbusy = 0;
        repeat (10) begin nbusy += (busy | tx_pulse) ? 1 : 0; step(); end
        check("send_level0_busy", nbusy, 0);

        push_ramp(1, 5, 0);
        pulse_cmd(M_INC, 5, 1);
        wait_level(5, 60, "ramp5");

        // 5 + 245 = 250, then +20 saturates at 255
        push_ramp(6, 255, 0);
        pulse_cmd(M_INC, 245, 1);
        repeat (5) step();
        pulse_cmd(M_INC, 20, 1);
        wait_level(255, 1200, "sat255");
        repeat (20) step();
        check("sat_hold", dac_data, 255);

        // 255 - 245 = 10, then 10 - 255 floors at 0
        push_ramp(254, 0, 0);
        pulse_cmd(M_DEC, 245, 1);
        repeat (5) step();
        pulse_cmd(M_DEC, 255, 1);
        wait_level(0, 1200, "floor0");

        push_ramp(1, 7, 0);
        push_ramp(8, 8, 0);
        push_ramp(9, 9, 0);
        push_ramp(10, 20, 1);
        pulse_cmd(M_INC, 20, 1);
        n = 0;
        while (!(dac_valid && dac_data == 8) && n < 100) begin step(); n++; end
        dac_ready = 1'b0;
        check("stall_reached", dac_data, 8);
        repeat (50) begin
            step();
            check("stall_valid", dac_valid, 1);
            check("stall_data", dac_data, 8);
        end
        dac_ready = 1'b1;
        wait_level(20, 200, "resume20");

        push_ramp(19, 3, 0);
        pulse_cmd(M_DEC, 17, 1);
        wait_level(3, 200, "lvl3");
        pulse_cmd(M_SEND, 0, 1);
        for (int i = 0; i < BP * PP; i++) begin
            check($sformatf("burst_tx[%0d]", i), tx_pulse, ((i % PP) < PP / 2) ? 1 : 0);
            check($sformatf("burst_busy[%0d]", i), busy, 1);
            step();
        end
        check("burst_end_busy", busy, 0);
        check("burst_end_tx", tx_pulse, 0);

        push_ramp(2, 0, 0);
        pulse_cmd(M_OFF, 0, 1);
        check("enabled_off", enabled, 0);
        pulse_cmd(M_SEND, 0, 1);
        nbusy = 0;
        repeat (10) begin nbusy += (busy | tx_pulse) ? 1 : 0; step(); end
        check("send_disabled_busy", nbusy, 0);
        wait_level(0, 100, "off_ramp0");

        push_ramp(1, 3, 0);
        pulse_cmd(M_ON, 0, 1);
        wait_level(3, 100, "lvl3b");
        pulse_cmd(M_RECV, 0, 1);
        n = 0;
        while (rx_window && busy && n < 1100) begin step(); n++; end
        check("rx_len", n, RXW);

        pulse_cmd(M_RECV, 0, 1);
        repeat (200) step();
        check("rx_before_off", rx_window, 1);
        push_ramp(2, 0, 0);
        pulse_cmd(M_OFF, 0, 1);
        check("abort_rx", rx_window, 0);
        check("abort_busy", busy, 0);
        check("abort_enabled", enabled, 0);
        wait_level(0, 100, "abort_ramp0");

        push_ramp(1, 3, 0);
        pulse_cmd(M_ON, 0, 1);
        wait_level(3, 100, "lvl3c");
        pulse_cmd(M_INC | M_DEC, 10, 1);
        repeat (30) step();
        check("incdec_ignored", dac_data, 3);
        pulse_cmd(M_INC, 10, 0);
        repeat (30) step();
        check("invalid_ignored", dac_data, 3);
        pulse_cmd(M_RECV, 0, 0);
        check("invalid_recv_busy", busy, 0);
        pulse_cmd(M_ON | M_OFF, 0, 1);
        repeat (10) step();
        check("onoff_ignored", enabled, 1);

        pulse_cmd(M_SEND, 0, 1);
        repeat (10) step();
        check("burst_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("post_reset_enabled", enabled, 0);
        check("post_reset_busy", busy, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/us_power_ctrl.md
# us_power_ctrl

Command-execution stage directly downstream of the host-word decoder in the ultrasonic drive path. Consumes the decoder's held level outputs (on, off, increase, decrease, valid, send, receive, amount) and turns their rising edges into actions. It maintains a saturating power target and slew-ramps the DAC code toward it over a valid/ready DAC interface. It also sequences transmit bursts and receive listening windows for the transducer.

## Interface
- DAC_WIDTH, 8, DAC code width; MAX_LEVEL = 2^DAC_WIDTH-1
- AMOUNT_WIDTH, 8, width of amount; must be <= DAC_WIDTH
- RAMP_DIV, 16, clocks per ramp opportunity (>=2)
- PULSE_PERIOD, 10, clocks per tx pulse period (even, >=2)
- BURST_PULSES, 8, pulses per burst (>=1)
- RX_WINDOW, 1000, clocks rx_window stays high (>=1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- on, off, increase, decrease, send, receive  in  1 each  held command levels from decoder
- valid  in  1  decoder validity; gates edge events
- amount  in  AMOUNT_WIDTH  step size for increase/decrease
- dac_valid  out  1  DAC write request
- dac_ready  in  1  DAC accepts when dac_valid && dac_ready
- dac_data  out  DAC_WIDTH  current level (equals level register)
- enabled  out  1  drive enabled flag
- tx_pulse  out  1  transducer drive pulse
- rx_window  out  1  receiver listening window
- busy  out  1  high in BURST or RX state

## Operation
- Reset: all outputs 0; target, level, counters, edge history 0; state IDLE.
- Edge detection: per command input, event = in && !prev, where prev is the value sampled on the previous clk. History always updates. Events in a cycle where valid=0 are dropped.
- on event sets enabled. off event clears enabled and aborts BURST/RX to IDLE the same edge. Simultaneous on+off events are ignored.
- increase event: target = min(target + amount, MAX_LEVEL), computed in DAC_WIDTH+1 bits with amount zero-extended. decrease event: target = max(target - amount, 0). Simultaneous increase+decrease are ignored. amount=0 leaves target unchanged.
- Effective target = enabled ? target : 0.
- Ramp: ramp counter free-runs 0..RAMP_DIV-1. At terminal count, if level != effective target and no transfer is pending (dac_valid=0), level moves 1 LSB toward it and dac_valid sets on the same edge.
- DAC handshake: dac_valid holds and dac_data stays stable until the dac_valid && dac_ready edge, which clears dac_valid. A missed opportunity due to a pending transfer waits for the next terminal count. No wrap-around of level or target is permitted.
- State machine IDLE/BURST/RX:
  - IDLE, send event, enabled=1 and level>0 -> BURST.
  - IDLE, receive event -> RX.
  - Events not listed, including send/receive in BURST/RX, are ignored.
  - BURST -> IDLE after BURST_PULSES periods.
  - RX -> IDLE after RX_WINDOW cycles.
  - off event from BURST/RX -> IDLE.
- tx_pulse is high during the first PULSE_PERIOD/2 cycles of each burst period and low otherwise. rx_window = (state==RX).

## Timing
- Command sampled at edge k: target/enabled/state updated at edge k, visible in the cycle after.
- BURST: tx_pulse high the cycle after entry; burst totals BURST_PULSES*PULSE_PERIOD cycles, then IDLE; tx_pulse low in final half period.
- RX: rx_window high for exactly RX_WINDOW cycles.
- Level changes at most once per RAMP_DIV cycles. A full 0->MAX_LEVEL ramp with dac_ready tied high takes MAX_LEVEL*RAMP_DIV cycles.
- Abort by off: tx_pulse/rx_window/busy low the cycle after the edge; ramp then heads to 0.
- Reset mid-operation: all outputs 0 asynchronously; a pending DAC transfer is discarded.

## Test plan
- Defaults with RAMP_DIV=4, dac_ready=1: on, then increase with amount=5 -> level steps 1..5, one dac_valid transfer every 4 cycles, dac_data final 5.
- target=250, increase amount=20 -> target saturates 255; decrease amount=255 from 10 -> target 0; no wrap.
- dac_ready held 0 for 50 cycles mid-ramp -> dac_valid stays high, dac_data stable, level frozen; release -> ramp resumes.
- enabled, level=3, send event -> 8 pulses, 5 high/5 low, busy 80 cycles; send with level=0 or enabled=0 -> no pulses.
- receive event -> rx_window high exactly 1000 cycles; off event at cycle 200 -> rx_window drops next cycle, level ramps to 0.
- Simultaneous increase+decrease edges, or any edge with valid=0 -> target unchanged; asserting rst_n low mid-burst -> all outputs 0 immediately.
